// File: rtl/cmplx_pkg.sv
// Shared types and helpers for the pipelined fixed-point complex multiplier.
// Widths derive from the Q format: W = INT_W+FRAC_W per component, 2W per product.
package cmplx_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } round_mode_e;

    localparam int DEF_INT_W  = 4;
    localparam int DEF_FRAC_W = 12;

    function automatic int comp_w(input int int_w, input int frac_w);
        return int_w + frac_w;
    endfunction

    function automatic int prod_w(input int int_w, input int frac_w);
        return 2 * (int_w + frac_w);
    endfunction

    localparam int DEF_W = comp_w(DEF_INT_W, DEF_FRAC_W);

    // {imag, real} pair at the default Q format; 'real' is a keyword, hence im/re.
    typedef struct packed {
        logic [DEF_W-1:0] im;
        logic [DEF_W-1:0] re;
    } cplx_t;

    // Clamp a signed value into the two's-complement range of 'width' bits.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/cmplx_round_sat.sv
// Rounds a 2W+1-bit fixed-point sum back to Q INT_W.FRAC_W and saturates it.
// Purely combinational; sat is high whenever clamping changed the value.
module cmplx_round_sat
    import cmplx_pkg::*;
#(
    parameter int INT_W      = 4,
    parameter int FRAC_W     = 12,
    parameter int ROUND_MODE = 1
) (
    input  logic [2*(INT_W+FRAC_W):0]   din,
    output logic [INT_W+FRAC_W-1:0]     dout,
    output logic                        sat
);

    localparam int W = comp_w(INT_W, FRAC_W);

    logic signed [63:0] wide;
    logic signed [63:0] biased;
    logic signed [63:0] shifted;
    logic signed [63:0] narrowed;

    always_comb begin
        wide = 64'($signed(din));
        // Round-half-up adds half an LSB of the result before the floor shift.
        if (ROUND_MODE == int'(RND_HALF_UP)) begin
            biased = wide + (64'sd1 <<< (FRAC_W - 1));
        end else begin
            biased = wide;
        end
        shifted  = biased >>> FRAC_W;
        narrowed = sat_narrow(shifted, W);
        dout     = narrowed[W-1:0];
        sat      = (narrowed != shifted);
    end

endmodule

// File: rtl/cmplx_mult_axis_pipe.sv
// Three-stage AXI-Stream complex multiplier: P = A*B or A*conj(B) per beat.
// Join of A and B, full back-pressure, rounding/saturation with a sticky flag.
module cmplx_mult_axis_pipe
    import cmplx_pkg::*;
#(
    parameter int INT_W      = 4,
    parameter int FRAC_W     = 12,
    parameter int ROUND_MODE = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            input_a_tvalid,
    output logic                            input_a_tready,
    input  logic [2*(INT_W+FRAC_W)-1:0]     input_a_tdata,
    input  logic                            input_b_tvalid,
    output logic                            input_b_tready,
    input  logic [2*(INT_W+FRAC_W)-1:0]     input_b_tdata,
    input  logic                            input_b_tuser,
    output logic                            output_prod_tvalid,
    input  logic                            output_prod_tready,
    output logic [2*(INT_W+FRAC_W)-1:0]     output_prod_tdata,
    output logic [1:0]                      output_prod_tuser,
    output logic                            sat_sticky,
    input  logic                            sat_clr
);

    localparam int W  = comp_w(INT_W, FRAC_W);
    localparam int PW = prod_w(INT_W, FRAC_W);
    localparam int SW = PW + 1;
    localparam logic [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] W_MAX = ~W_MIN;

    // Handshake: a beat moves on a clock edge where its valid and the receiver's
    // ready are both high; stage k accepts when empty or when stage k+1 accepts,
    // and ready is built only from valids and output_prod_tready, never from data.
    logic rdy1, rdy2, rdy3, fire;
    logic s1_v, s2_v;

    assign rdy3           = !output_prod_tvalid | output_prod_tready;
    assign rdy2           = !s2_v | rdy3;
    assign rdy1           = !s1_v | rdy2;
    assign fire           = input_a_tvalid & input_b_tvalid & rdy1;
    assign input_a_tready = input_b_tvalid & rdy1;
    assign input_b_tready = input_a_tvalid & rdy1;

    // S1: operand capture with optional conjugation of B.
    logic [W-1:0] b_im_adj;
    logic         neg_sat;

    always_comb begin
        neg_sat  = input_b_tuser && (input_b_tdata[2*W-1:W] == W_MIN);
        b_im_adj = input_b_tdata[2*W-1:W];
        if (input_b_tuser) begin
            b_im_adj = neg_sat ? W_MAX : (~input_b_tdata[2*W-1:W] + 1'b1);
        end
    end

    logic signed [W-1:0] s1_ar, s1_ai, s1_br, s1_bi;
    logic                s1_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_ar  <= '0;
            s1_ai  <= '0;
            s1_br  <= '0;
            s1_bi  <= '0;
            s1_sat <= 1'b0;
        end else if (rdy1) begin
            s1_v <= fire;
            if (fire) begin
                s1_ar  <= input_a_tdata[W-1:0];
                s1_ai  <= input_a_tdata[2*W-1:W];
                s1_br  <= input_b_tdata[W-1:0];
                s1_bi  <= b_im_adj;
                s1_sat <= neg_sat;
            end
        end
    end

    // S2: the four partial products, full precision.
    logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
    logic                 s2_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v   <= 1'b0;
            s2_rr  <= '0;
            s2_ii  <= '0;
            s2_ri  <= '0;
            s2_ir  <= '0;
            s2_sat <= 1'b0;
        end else if (rdy2) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_rr  <= PW'(s1_ar) * PW'(s1_br);
                s2_ii  <= PW'(s1_ai) * PW'(s1_bi);
                s2_ri  <= PW'(s1_ar) * PW'(s1_bi);
                s2_ir  <= PW'(s1_ai) * PW'(s1_br);
                s2_sat <= s1_sat;
            end
        end
    end

    // S3: sums at 2W+1 bits cannot overflow; narrowing happens in round_sat.
    logic signed [SW-1:0] sum_r, sum_i;
    logic [W-1:0]         res_r, res_i;
    logic                 sat_r, sat_i, any_sat;

    assign sum_r   = SW'(s2_rr) - SW'(s2_ii);
    assign sum_i   = SW'(s2_ri) + SW'(s2_ir);
    assign any_sat = sat_r | sat_i | s2_sat;

    cmplx_round_sat #(.INT_W(INT_W), .FRAC_W(FRAC_W), .ROUND_MODE(ROUND_MODE)) u_rs_real (
        .din  (sum_r),
        .dout (res_r),
        .sat  (sat_r)
    );

    cmplx_round_sat #(.INT_W(INT_W), .FRAC_W(FRAC_W), .ROUND_MODE(ROUND_MODE)) u_rs_imag (
        .din  (sum_i),
        .dout (res_i),
        .sat  (sat_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_prod_tvalid <= 1'b0;
            output_prod_tdata  <= '0;
            output_prod_tuser  <= '0;
        end else if (rdy3) begin
            output_prod_tvalid <= s2_v;
            if (s2_v) begin
                output_prod_tdata <= {res_i, res_r};
                output_prod_tuser <= {sat_i | s2_sat, sat_r | s2_sat};
            end
        end
    end

    // A saturated beat landing in the output register beats a concurrent clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_sticky <= 1'b0;
        end else if (rdy3 && s2_v && any_sat) begin
            sat_sticky <= 1'b1;
        end else if (sat_clr) begin
            sat_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmplx_mult_axis_pipe.sv
// Bench for cmplx_mult_axis_pipe: a round-half-up and a truncating instance share
// the same stimulus; a monitor scores both outputs against a reference model.
module tb_cmplx_mult_axis_pipe;
    import cmplx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, b_user, out_ready, sat_clr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, out_valid, sticky;
    logic [31:0] out_data;
    logic [1:0]  out_user;
    logic        t_a_ready, t_b_ready, t_out_valid, t_sticky;
    logic [31:0] t_out_data;
    logic [1:0]  t_out_user;

    logic [33:0] exp_q[$];
    logic [33:0] exp_t_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fire_cnt = 0;
    logic [31:0] last_data, last_t_data;
    logic [1:0]  last_user;

    always #5 clk = ~clk;

    cmplx_mult_axis_pipe #(.INT_W(4), .FRAC_W(12), .ROUND_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .input_a_tvalid(a_valid), .input_a_tready(a_ready), .input_a_tdata(a_data),
        .input_b_tvalid(b_valid), .input_b_tready(b_ready), .input_b_tdata(b_data),
        .input_b_tuser(b_user),
        .output_prod_tvalid(out_valid), .output_prod_tready(out_ready),
        .output_prod_tdata(out_data), .output_prod_tuser(out_user),
        .sat_sticky(sticky), .sat_clr(sat_clr)
    );

    cmplx_mult_axis_pipe #(.INT_W(4), .FRAC_W(12), .ROUND_MODE(0)) dut_trunc (
        .clk(clk), .rst_n(rst_n),
        .input_a_tvalid(a_valid), .input_a_tready(t_a_ready), .input_a_tdata(a_data),
        .input_b_tvalid(b_valid), .input_b_tready(t_b_ready), .input_b_tdata(b_data),
        .input_b_tuser(b_user),
        .output_prod_tvalid(t_out_valid), .output_prod_tready(out_ready),
        .output_prod_tdata(t_out_data), .output_prod_tuser(t_out_user),
        .sat_sticky(t_sticky), .sat_clr(sat_clr)
    );

    // Reference: exact integer product, then round/floor, then clamp to Q4.12.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input int rm);
        longint ar, ai, br, bi, pr, pi;
        logic   nsat, sr, si;
        cplx_t  p;
        ar = longint'($signed(a[15:0]));
        ai = longint'($signed(a[31:16]));
        br = longint'($signed(b[15:0]));
        bi = longint'($signed(b[31:16]));
        nsat = 1'b0;
        if (c) begin
            bi = -bi;
            if (bi > 32767) begin
                bi = 32767;
                nsat = 1'b1;
            end
        end
        pr = ar * br - ai * bi;
        pi = ar * bi + ai * br;
        if (rm == 1) begin
            pr = pr + 2048;
            pi = pi + 2048;
        end
        pr = pr >>> 12;
        pi = pi >>> 12;
        sr = 1'b0;
        si = 1'b0;
        if (pr > 32767) begin pr = 32767; sr = 1'b1; end
        else if (pr < -32768) begin pr = -32768; sr = 1'b1; end
        if (pi > 32767) begin pi = 32767; si = 1'b1; end
        else if (pi < -32768) begin pi = -32768; si = 1'b1; end
        p.re = pr[15:0];
        p.im = pi[15:0];
        return {si | nsat, sr | nsat, p};
    endfunction

    task automatic monitor();
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected got=%h_%h", out_user, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_user, out_data} !== e) begin
                            errors++;
                            $display("FAIL out_round got=%h_%h exp=%h_%h", out_user, out_data, e[33:32], e[31:0]);
                        end
                    end
                    last_data = out_data;
                    last_user = out_user;
                end
                if (t_out_valid && out_ready) begin
                    checks++;
                    if (exp_t_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_trunc_unexpected got=%h_%h", t_out_user, t_out_data);
                    end else begin
                        e = exp_t_q.pop_front();
                        if ({t_out_user, t_out_data} !== e) begin
                            errors++;
                            $display("FAIL out_trunc got=%h_%h exp=%h_%h", t_out_user, t_out_data, e[33:32], e[31:0]);
                        end
                    end
                    last_t_data = t_out_data;
                end
                if (a_valid && b_valid && a_ready) begin
                    exp_q.push_back(model(a_data, b_data, b_user, 1));
                    exp_t_q.push_back(model(a_data, b_data, b_user, 0));
                    fire_cnt++;
                end
            end
        end
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic c);
        int n;
        a_data  = a;
        b_data  = b;
        b_user  = c;
        a_valid = 1'b1;
        b_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=no_accept exp=accept");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_t_q.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_t_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d_left exp=0_left", exp_q.size());
        end
    endtask

    task automatic check_latency(input string name);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s got=%0d exp=3", name, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
    endtask

    task automatic test_reset();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%b exp=0", out_valid); end
        if (out_data !== 32'h0) begin errors++; $display("FAIL rst_tdata got=%h exp=0", out_data); end
        if (out_user !== 2'b00) begin errors++; $display("FAIL rst_tuser got=%b exp=00", out_user); end
        if (sticky !== 1'b0) begin errors++; $display("FAIL rst_sticky got=%b exp=0", sticky); end
        if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got=%b exp=0", a_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_beat(32'h1000_1000, 32'h1000_1000, 1'b0);
        idle();
        check_latency("basic_latency");
        wait_drain();
        checks += 2;
        if (last_data !== 32'h2000_0000) begin errors++; $display("FAIL basic_data got=%h exp=20000000", last_data); end
        if (last_user !== 2'b00) begin errors++; $display("FAIL basic_user got=%b exp=00", last_user); end
    endtask

    task automatic test_conj();
        send_beat(32'h1000_1000, 32'h1000_1000, 1'b1);
        idle();
        wait_drain();
        checks++;
        if (last_data !== 32'h0000_2000) begin errors++; $display("FAIL conj_data got=%h exp=00002000", last_data); end
    endtask

    task automatic test_rounding();
        send_beat(32'h0000_0001, 32'h0000_0800, 1'b0);
        idle();
        wait_drain();
        checks += 2;
        if (last_data[15:0] !== 16'h0001) begin errors++; $display("FAIL round_half_up got=%h exp=0001", last_data[15:0]); end
        if (last_t_data[15:0] !== 16'h0000) begin errors++; $display("FAIL round_trunc got=%h exp=0000", last_t_data[15:0]); end
    endtask

    task automatic test_saturation();
        send_beat(32'h0000_7FFF, 32'h0000_7FFF, 1'b0);
        idle();
        wait_drain();
        checks += 3;
        if (last_data !== 32'h0000_7FFF) begin errors++; $display("FAIL sat_data got=%h exp=00007fff", last_data); end
        if (last_user !== 2'b01) begin errors++; $display("FAIL sat_user got=%b exp=01", last_user); end
        if (sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky_set got=%b exp=1", sticky); end
        pulse_clr();
        checks++;
        if (sticky !== 1'b0) begin errors++; $display("FAIL sat_sticky_clr got=%b exp=0", sticky); end
        // -8.0 * 1.0 sits exactly on the negative bound without saturating.
        send_beat(32'h0000_8000, 32'h0000_1000, 1'b0);
        idle();
        wait_drain();
        checks += 3;
        if (last_data !== 32'h0000_8000) begin errors++; $display("FAIL neg_bound_data got=%h exp=00008000", last_data); end
        if (last_user !== 2'b00) begin errors++; $display("FAIL neg_bound_user got=%b exp=00", last_user); end
        if (sticky !== 1'b0) begin errors++; $display("FAIL neg_bound_sticky got=%b exp=0", sticky); end
        // Conjugating bi = -8.0 clamps to +7.9998 and flags both components.
        send_beat(32'h1000_0000, 32'h8000_0000, 1'b1);
        idle();
        wait_drain();
        checks += 2;
        if (last_data !== 32'h0000_8001) begin errors++; $display("FAIL conj_min_data got=%h exp=00008001", last_data); end
        if (last_user !== 2'b11) begin errors++; $display("FAIL conj_min_user got=%b exp=11", last_user); end
        pulse_clr();
        // Clear asserted on the very edge the saturated beat is registered.
        send_beat(32'h0000_7FFF, 32'h0000_7FFF, 1'b0);
        idle();
        @(posedge clk);
        #1;
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        checks++;
        if (sticky !== 1'b1) begin errors++; $display("FAIL sat_set_wins got=%b exp=1", sticky); end
        wait_drain();
        pulse_clr();
    endtask

    task automatic test_back_pressure();
        int          fire0;
        logic [31:0] held;
        out_ready = 1'b0;
        fire0 = fire_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_beat($urandom, $urandom, 1'($urandom_range(0, 1)));
                end
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                held = out_data;
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    checks++;
                    if (out_data !== held || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_stable got=%h exp=%h", out_data, held);
                    end
                end
                checks += 3;
                if (fire_cnt - fire0 != 3) begin errors++; $display("FAIL bp_buffered got=%0d exp=3", fire_cnt - fire0); end
                if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_a_ready got=%b exp=0", a_ready); end
                if (b_ready !== 1'b0) begin errors++; $display("FAIL bp_b_ready got=%b exp=0", b_ready); end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (fire_cnt - fire0 != 8) begin errors++; $display("FAIL bp_total got=%0d exp=8", fire_cnt - fire0); end
    endtask

    task automatic test_join_reset();
        int fire0;
        out_ready = 1'b1;
        fire0 = fire_cnt;
        a_data  = 32'h1000_1000;
        b_data  = 32'h1000_1000;
        b_user  = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks += 4;
        if (a_ready !== 1'b0) begin errors++; $display("FAIL join_a_ready got=%b exp=0", a_ready); end
        if (b_ready !== 1'b1) begin errors++; $display("FAIL join_b_ready got=%b exp=1", b_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL join_no_out got=%b exp=0", out_valid); end
        if (fire_cnt != fire0) begin errors++; $display("FAIL join_no_fire got=%0d exp=%0d", fire_cnt, fire0); end
        @(posedge clk);
        #1;
        // Saturating stream so the sticky flag is set when reset hits.
        a_data  = 32'h0000_7FFF;
        b_data  = 32'h0000_7FFF;
        b_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got=%b exp=1", out_valid); end
        if (sticky !== 1'b1) begin errors++; $display("FAIL pre_rst_sticky got=%b exp=1", sticky); end
        #1;
        rst_n = 1'b0;
        idle();
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        if (sticky !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky got=%b exp=0", sticky); end
        if (out_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data got=%h exp=0", out_data); end
        exp_q.delete();
        exp_t_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_beat(32'h1000_1000, 32'h1000_1000, 1'b1);
        idle();
        check_latency("post_rst_latency");
        wait_drain();
        checks++;
        if (last_data !== 32'h0000_2000) begin errors++; $display("FAIL post_rst_data got=%h exp=00002000", last_data); end
    endtask

    initial begin
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        b_user    = 1'b0;
        a_data    = '0;
        b_data    = '0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;
        last_data   = '0;
        last_t_data = '0;
        last_user   = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        fork
            monitor();
        join_none
        @(posedge clk);
        #1;
        test_basic();
        test_conj();
        test_rounding();
        test_saturation();
        test_back_pressure();
        test_join_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
